// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with hardware return-address stack
module pc_sequencer #(
    parameter int len         = 16,
    parameter int sumando     = 1,
    parameter int RESET_PC    = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           enable_i,
    input  logic           stall_i,
    input  logic           halt_i,
    input  logic           jmp_i,
    input  logic [len-1:0] jmp_addr_i,
    input  logic           branch_i,
    input  logic [len-1:0] branch_off_i,
    input  logic           call_i,
    input  logic [len-1:0] call_addr_i,
    input  logic           ret_i,
    output logic [len-1:0] pc_o,
    output logic [len-1:0] pc_plus_o,
    output logic           halted_o,
    output logic           stack_empty_o,
    output logic           stack_full_o,
    output logic           stack_err_o
);

    // Stack index width and occupancy-count width (count must reach STACK_DEPTH).
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [len-1:0]  pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [len-1:0]  mem_q [STACK_DEPTH];

    logic            update;
    logic            push_we;
    logic            is_empty;
    logic            is_full;
    logic [PW-1:0]   wr_idx;
    logic [PW-1:0]   rd_idx;
    logic [len-1:0]  pc_inc;
    logic [len-1:0]  pc_branch;

    // Incrementer and branch adder wrap modulo 2^len by truncation.
    assign pc_inc    = pc_q + len'(sumando);
    assign pc_branch = pc_q + branch_off_i;

    // Top-of-stack sits at count-1; the next free slot is at count.
    assign wr_idx   = PW'(cnt_q);
    assign rd_idx   = PW'(cnt_q - CW'(1));
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(STACK_DEPTH));

    // Only RUN cycles with enable and no stall may change any state.
    assign update = (state_q == ST_RUN) && enable_i && !stall_i;

    // Next-state, next-PC and stack control, one prioritised action per update cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_we = 1'b0;
        if (update) begin
            if (halt_i) begin
                state_d = ST_HALTED;
            end else if (ret_i) begin
                if (!is_empty) begin
                    pc_d  = mem_q[rd_idx];
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (call_i) begin
                if (!is_full) begin
                    push_we = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    pc_d    = call_addr_i;
                end else begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (jmp_i) begin
                pc_d = jmp_addr_i;
            end else if (branch_i) begin
                pc_d = pc_branch;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Control state: PC, FSM state, stack occupancy and sticky error.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            pc_q    <= len'(RESET_PC);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; contents survive reset, only the count is cleared.
    always_ff @(posedge clk_i) begin
        if (push_we && !reset_i) begin
            mem_q[wr_idx] <= pc_inc;
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus_o     = pc_inc;
    assign halted_o      = (state_q == ST_HALTED);
    assign stack_empty_o = is_empty;
    assign stack_full_o  = is_full;
    assign stack_err_o   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk, reset, enable, stall, halt, jmp, branch, call, ret;
    logic [15:0] jmp_addr, branch_off, call_addr;
    logic [15:0] pc, pc_plus;
    logic        halted, stack_empty, stack_full, stack_err;

    int checks = 0;
    int errors = 0;

    // Reference model: PC value, return stack as a queue, halted and error flags.
    logic [15:0] m_pc;
    logic [15:0] m_stk [$];
    bit          m_halted;
    bit          m_err;

    pc_sequencer #(.len(16), .sumando(1), .RESET_PC(0), .STACK_DEPTH(4)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .stall_i(stall),
        .halt_i(halt), .jmp_i(jmp), .jmp_addr_i(jmp_addr), .branch_i(branch),
        .branch_off_i(branch_off), .call_i(call), .call_addr_i(call_addr), .ret_i(ret),
        .pc_o(pc), .pc_plus_o(pc_plus), .halted_o(halted), .stack_empty_o(stack_empty),
        .stack_full_o(stack_full), .stack_err_o(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 16'h0000;
        m_stk.delete();
        m_halted = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        if (!m_halted && enable && !stall) begin
            if (halt) m_halted = 1'b1;
            else if (ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_err = 1'b1; m_pc = m_pc + 16'd1; end
            end else if (call) begin
                if (m_stk.size() < 4) begin m_stk.push_back(m_pc + 16'd1); m_pc = call_addr; end
                else begin m_err = 1'b1; m_pc = m_pc + 16'd1; end
            end else if (jmp) m_pc = jmp_addr;
            else if (branch) m_pc = m_pc + branch_off;
            else m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic clear_reqs();
        halt = 0; jmp = 0; branch = 0; call = 0; ret = 0; stall = 0;
        jmp_addr = 0; branch_off = 0; call_addr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; clear_reqs();
        step(); step();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
        checks++; if (pc_plus !== 16'h0001) begin errors++; $display("FAIL reset_pc_plus got %h exp 0001", pc_plus); end
        checks++; if ({halted, stack_empty, stack_full, stack_err} !== 4'b0100) begin
            errors++; $display("FAIL reset_flags got %b exp 0100", {halted, stack_empty, stack_full, stack_err}); end
        reset = 0;
    endtask

    task automatic test_increment();
        enable = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++; if (pc !== 16'(i)) begin errors++; $display("FAIL incr got %h exp %h", pc, 16'(i)); end
        end
        jmp = 1; jmp_addr = 16'hFFFF; step(); jmp = 0;
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL jmp_ffff got %h exp ffff", pc); end
        checks++; if (pc_plus !== 16'h0000) begin errors++; $display("FAIL pc_plus_wrap got %h exp 0000", pc_plus); end
        step();
        checks++; if (pc !== 16'h0000 || stack_err !== 1'b0) begin
            errors++; $display("FAIL wrap got pc %h err %b exp 0000 0", pc, stack_err); end
    endtask

    task automatic test_branch();
        jmp = 1; jmp_addr = 16'h0010; step(); jmp = 0;
        branch = 1; branch_off = 16'hFFFC; step();
        checks++; if (pc !== 16'h000C) begin errors++; $display("FAIL branch_back got %h exp 000c", pc); end
        branch_off = 16'h0005; step(); branch = 0;
        checks++; if (pc !== 16'h0011) begin errors++; $display("FAIL branch_fwd got %h exp 0011", pc); end
    endtask

    task automatic test_call_chain();
        jmp = 1; jmp_addr = 16'h0020; step(); jmp = 0;
        call = 1; call_addr = 16'h0100; step(); call = 0;
        checks++; if (pc !== 16'h0100 || stack_empty !== 1'b0) begin
            errors++; $display("FAIL call1 got pc %h empty %b exp 0100 0", pc, stack_empty); end
        jmp = 1; jmp_addr = 16'h0105; step(); jmp = 0;
        call = 1; call_addr = 16'h0200; step(); call = 0;
        checks++; if (pc !== 16'h0200) begin errors++; $display("FAIL call2 got %h exp 0200", pc); end
        ret = 1; step();
        checks++; if (pc !== 16'h0106) begin errors++; $display("FAIL ret1 got %h exp 0106", pc); end
        step(); ret = 0;
        checks++; if (pc !== 16'h0021 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL ret2 got pc %h empty %b exp 0021 1", pc, stack_empty); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_pop [5];
        exp_pop = '{16'h0303, 16'h0302, 16'h0301, 16'h0022, 16'h0023};
        call = 1;
        for (int i = 0; i < 4; i++) begin
            call_addr = 16'h0300 + 16'(i); step();
        end
        checks++; if (stack_full !== 1'b1 || stack_err !== 1'b0 || pc !== 16'h0303) begin
            errors++; $display("FAIL fill got full %b err %b pc %h exp 1 0 0303", stack_full, stack_err, pc); end
        call_addr = 16'h0900; step(); call = 0;
        checks++; if (stack_err !== 1'b1 || pc !== 16'h0304 || stack_full !== 1'b1) begin
            errors++; $display("FAIL overflow got err %b pc %h full %b exp 1 0304 1", stack_err, pc, stack_full); end
        ret = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (pc !== exp_pop[i] || pc !== m_pc) begin
                errors++; $display("FAIL pop%0d got %h exp %h", i, pc, exp_pop[i]); end
        end
        ret = 0;
        checks++; if (stack_err !== 1'b1 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL underflow got err %b empty %b exp 1 1", stack_err, stack_empty); end
    endtask

    task automatic test_priority();
        call = 1; call_addr = 16'h0400; step();
        ret = 1; jmp = 1; jmp_addr = 16'h0777; call_addr = 16'h0888; step();
        clear_reqs();
        checks++; if (pc !== 16'h0024 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL priority got pc %h empty %b exp 0024 1", pc, stack_empty); end
    endtask

    task automatic test_stall();
        stall = 1; jmp = 1; jmp_addr = 16'h0500;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 16'h0024) begin errors++; $display("FAIL stall_hold got %h exp 0024", pc); end
        end
        jmp = 0; halt = 1; step(); halt = 0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_in_stall got %b exp 0", halted); end
        enable = 0; halt = 1; step(); halt = 0; enable = 1;
        checks++; if (halted !== 1'b0 || pc !== 16'h0024) begin
            errors++; $display("FAIL halt_disabled got %b pc %h exp 0 0024", halted, pc); end
        jmp = 1; step(); stall = 0; step(); jmp = 0;
        checks++; if (pc !== 16'h0500) begin errors++; $display("FAIL stall_release got %h exp 0500", pc); end
        step();
        checks++; if (pc !== 16'h0501) begin errors++; $display("FAIL after_jump got %h exp 0501", pc); end
    endtask

    task automatic test_halt();
        jmp = 1; jmp_addr = 16'h0030; step(); jmp = 0;
        halt = 1; step(); halt = 0;
        jmp = 1; jmp_addr = 16'h0700;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (pc !== 16'h0030 || halted !== 1'b1) begin
                errors++; $display("FAIL halted_hold got pc %h halted %b exp 0030 1", pc, halted); end
        end
        jmp = 0;
    endtask

    task automatic test_async_reset();
        #2; reset = 1; #1;
        model_reset();
        checks++; if (pc !== 16'h0000 || halted !== 1'b0 || stack_err !== 1'b0 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL async_reset got pc %h halted %b err %b empty %b exp 0000 0 0 1",
                               pc, halted, stack_err, stack_empty); end
        #1; reset = 0;
        step();
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL post_reset got %h exp 0001", pc); end
    endtask

    task automatic test_random();
        logic [20:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            enable = ($urandom_range(0, 7) != 0);
            stall  = ($urandom_range(0, 5) == 0);
            halt   = ($urandom_range(0, 63) == 0);
            ret    = ($urandom_range(0, 3) == 0);
            call   = ($urandom_range(0, 2) == 0);
            jmp    = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 2) == 0);
            jmp_addr = 16'($urandom); branch_off = 16'($urandom); call_addr = 16'($urandom);
            step();
            got = {pc, halted, stack_empty, stack_full, stack_err, pc_plus[0]};
            exp = {m_pc, m_halted, (m_stk.size() == 0), (m_stk.size() == 4), m_err, ~m_pc[0]};
            checks++; if (got !== exp) begin
                errors++; $display("FAIL random%0d got %h exp %h", n, got, exp); end
            if (m_halted && $urandom_range(0, 3) == 0) begin
                #2; reset = 1; #1; model_reset(); #1; reset = 0;
            end
        end
        clear_reqs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_increment();
        test_branch();
        test_call_chain();
        test_overflow();
        test_priority();
        test_stall();
        test_halt();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
